// File: rtl/sb_mem_slave_pkg.sv
// Shared constants, FSM state type and access-check helpers for the sb data memory responder.
package sb_mem_slave_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int BYTE_SEL       = 2;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WACK = 2'b01,
        ST_RD   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Reserved size or an address not aligned to the access size.
    function automatic logic size_align_err(input logic [1:0] size, input logic [BYTE_SEL-1:0] lane);
        logic e;
        case (size)
            SIZE_B:  e = 1'b0;
            SIZE_H:  e = lane[0];
            SIZE_W:  e = (lane != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [BYTE_SEL-1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << lane;
            SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sb_ld_fmt.sv
// Load formatter: selects the addressed byte/halfword of a raw word and zero- or sign-extends it.
module sb_ld_fmt
    import sb_mem_slave_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [BYTE_SEL-1:0]   lane,
    input  logic [1:0]            size,
    input  logic                  un_sign,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension to the full data width
    always_comb begin
        case (lane)
            2'b00:   byte_s = raw[7:0];
            2'b01:   byte_s = raw[15:8];
            2'b10:   byte_s = raw[23:16];
            default: byte_s = raw[31:24];
        endcase
        if (lane[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
        case (size)
            SIZE_B: begin
                if (un_sign) begin
                    data = {24'h000000, byte_s};
                end else begin
                    data = {{24{byte_s[7]}}, byte_s};
                end
            end
            SIZE_H: begin
                if (un_sign) begin
                    data = {16'h0000, half_s};
                end else begin
                    data = {{16{half_s[15]}}, half_s};
                end
            end
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/sb_mem_slave.sv
// Single-port data memory responder on the sb bus: one request at a time, write ack after one
// cycle, formatted read data after two, with size/alignment/range error reporting.
module sb_mem_slave
    import sb_mem_slave_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req_i,
    input  logic              s_rw_i,
    input  logic [ADDR_W-1:0] s_addr_i,
    input  logic [DATA_W-1:0] s_wdata_i,
    input  logic [1:0]        s_byte_mask_i,
    input  logic              s_un_sign_i,
    output logic              s_ready_o,
    output logic              s_ack_o,
    output logic              s_rvalid_o,
    output logic [DATA_W-1:0] s_rdata_o,
    output logic              s_err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);

    logic [DATA_W-1:0]   mem_r [DEPTH];

    state_t              state_r;
    logic [BYTE_SEL-1:0] lane_r;
    logic [1:0]          size_r;
    logic                un_sign_r;
    logic                req_err_r;
    logic [DATA_W-1:0]   raw_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                ack_r;
    logic                rvalid_r;
    logic                err_r;

    logic                accept_s;
    logic                range_err_s;
    logic                err_s;
    logic                we_s;
    logic [3:0]          be_s;
    logic [DATA_W-1:0]   wlane_s;
    logic [DATA_W-1:0]   fmt_s;
    logic [IDX_W-1:0]    idx_s;

    assign s_ready_o   = (state_r == ST_IDLE);
    assign accept_s    = s_req_i & s_ready_o & ~rst;
    assign idx_s       = s_addr_i[IDX_W+1:2];
    assign range_err_s = (s_addr_i[ADDR_W-1:2] >= DEPTH_LIM);
    assign err_s       = range_err_s | size_align_err(s_byte_mask_i, s_addr_i[1:0]);
    assign we_s        = accept_s & s_rw_i & ~err_s;
    assign be_s        = lane_enables(s_byte_mask_i, s_addr_i[1:0]) & {4{we_s}};

    // Replicate store data so every enabled lane sees its right-aligned source bits
    always_comb begin
        case (s_byte_mask_i)
            SIZE_B:  wlane_s = {4{s_wdata_i[7:0]}};
            SIZE_H:  wlane_s = {2{s_wdata_i[15:0]}};
            default: wlane_s = s_wdata_i;
        endcase
    end

    // Array access at the acceptance edge: byte-lane write, raw word read (contents never reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
            end
        end
        if (accept_s && !s_rw_i) begin
            raw_r <= mem_r[idx_s];
        end
    end

    sb_ld_fmt u_ld_fmt (
        .raw     (raw_r),
        .lane    (lane_r),
        .size    (size_r),
        .un_sign (un_sign_r),
        .data    (fmt_s)
    );

    // Transaction FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            lane_r    <= 2'b00;
            size_r    <= 2'b00;
            un_sign_r <= 1'b0;
            req_err_r <= 1'b0;
            ack_r     <= 1'b0;
            rvalid_r  <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r    <= 1'b0;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    if (s_req_i) begin
                        lane_r    <= s_addr_i[1:0];
                        size_r    <= s_byte_mask_i;
                        un_sign_r <= s_un_sign_i;
                        req_err_r <= err_s;
                        if (s_rw_i) begin
                            state_r <= ST_WACK;
                            ack_r   <= 1'b1;
                            err_r   <= err_s;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WACK: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                end
                ST_RD: begin
                    state_r  <= ST_RESP;
                    rvalid_r <= 1'b1;
                    err_r    <= req_err_r;
                    if (req_err_r) begin
                        rdata_r <= 32'h0000_0000;
                    end else begin
                        rdata_r <= fmt_s;
                    end
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ack_r    <= 1'b0;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ack_o    = ack_r;
    assign s_rvalid_o = rvalid_r;
    assign s_err_o    = err_r;
    assign s_rdata_o  = rdata_r;

endmodule

// File: tb/tb_sb_mem_slave.sv
// Self-checking bench for sb_mem_slave: directed scenarios plus randomized traffic against a byte-array model.
module tb_sb_mem_slave;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_req_i = 1'b0;
    logic        s_rw_i = 1'b0;
    logic [31:0] s_addr_i = 32'h0;
    logic [31:0] s_wdata_i = 32'h0;
    logic [1:0]  s_byte_mask_i = 2'b00;
    logic        s_un_sign_i = 1'b0;
    logic        s_ready_o, s_ack_o, s_rvalid_o, s_err_o;
    logic [31:0] s_rdata_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_b [0:63];

    sb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_req_i(s_req_i), .s_rw_i(s_rw_i), .s_addr_i(s_addr_i),
        .s_wdata_i(s_wdata_i), .s_byte_mask_i(s_byte_mask_i), .s_un_sign_i(s_un_sign_i),
        .s_ready_o(s_ready_o), .s_ack_o(s_ack_o), .s_rvalid_o(s_rvalid_o),
        .s_rdata_o(s_rdata_o), .s_err_o(s_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz, input logic un);
        logic [7:0]  b;
        logic [15:0] h;
        if (model_err(a, sz)) return 32'h0;
        if (sz == 2'd0) begin
            b = ref_b[a];
            return un ? {24'h0, b} : 32'($signed(b));
        end
        if (sz == 2'd1) begin
            h = {ref_b[a+1], ref_b[a]};
            return un ? {16'h0, h} : 32'($signed(h));
        end
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        if (!model_err(a, sz)) begin
            for (int i = 0; i < (1 << sz); i++) ref_b[a+i] = d[8*i +: 8];
        end
    endfunction

    // Issue one write from an IDLE cycle; returns ack/err in WACK and ack one cycle later.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             output logic ack, output logic err, output logic ack_after);
        s_req_i = 1'b1; s_rw_i = 1'b1; s_addr_i = a; s_wdata_i = d; s_byte_mask_i = sz; s_un_sign_i = 1'b0;
        @(posedge clk); #1;
        s_req_i = 1'b0;
        ack = s_ack_o; err = s_err_o;
        model_write(a, d, sz);
        @(posedge clk); #1;
        ack_after = s_ack_o;
    endtask

    // Issue one read from an IDLE cycle; returns rvalid one cycle after accept and the response two cycles after.
    task automatic bus_read(input logic [31:0] a, input logic [1:0] sz, input logic un,
                            output logic early, output logic rv, output logic [31:0] data, output logic err);
        s_req_i = 1'b1; s_rw_i = 1'b0; s_addr_i = a; s_byte_mask_i = sz; s_un_sign_i = un;
        @(posedge clk); #1;
        s_req_i = 1'b0;
        early = s_rvalid_o;
        @(posedge clk); #1;
        rv = s_rvalid_o; data = s_rdata_o; err = s_err_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b exp 0", s_ack_o); end
        total++; if (s_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b exp 0", s_rvalid_o); end
        total++; if (s_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", s_err_o); end
        total++; if (s_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", s_rdata_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (s_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", s_ready_o); end
    endtask

    task automatic test_fill();
        logic ack, err, ack2;
        for (int w = 0; w < 16; w++) begin
            bus_write(32'(w * 4), $urandom, 2'd2, ack, err, ack2);
            total++; if (ack !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL fill_ack: got ack=%b err=%b exp ack=1 err=0", ack, err); end
        end
    endtask

    task automatic test_word();
        logic ack, err, ack2, early, rv;
        logic [31:0] d;
        bus_write(32'h4, 32'hDEADBEEF, 2'd2, ack, err, ack2);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL word_ack: got %b exp 1", ack); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL word_werr: got %b exp 0", err); end
        total++; if (ack2 !== 1'b0) begin bad++; $display("FAIL word_ack_pulse: got %b exp 0", ack2); end
        bus_read(32'h4, 2'd2, 1'b0, early, rv, d, err);
        total++; if (early !== 1'b0) begin bad++; $display("FAIL word_early_rvalid: got %b exp 0", early); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL word_rvalid: got %b exp 1", rv); end
        total++; if (d !== model_read(32'h4, 2'd2, 1'b0)) begin bad++; $display("FAIL word_rdata: got %h exp %h", d, model_read(32'h4, 2'd2, 1'b0)); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL word_rerr: got %b exp 0", err); end
        total++; if (s_rvalid_o !== 1'b0) begin bad++; $display("FAIL word_rvalid_pulse: got %b exp 0", s_rvalid_o); end
        total++; if (s_rdata_o !== d) begin bad++; $display("FAIL word_rdata_hold: got %h exp %h", s_rdata_o, d); end
    endtask

    task automatic test_byte_ext();
        logic early, rv, err;
        logic [31:0] d, a;
        for (int k = 0; k < 4; k++) begin
            a = (k % 2 == 0) ? 32'h5 : 32'h6;
            bus_read(a, 2'd0, 1'(k / 2), early, rv, d, err);
            total++; if (d !== model_read(a, 2'd0, 1'(k / 2)) || rv !== 1'b1 || err !== 1'b0)
                begin bad++; $display("FAIL byte_ext: got %h rv=%b err=%b exp %h", d, rv, err, model_read(a, 2'd0, 1'(k / 2))); end
        end
    endtask

    task automatic test_half();
        logic ack, err, ack2, early, rv;
        logic [31:0] d;
        bus_write(32'h6, 32'h0000_1234, 2'd1, ack, err, ack2);
        total++; if (ack !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL half_write: got ack=%b err=%b exp 1/0", ack, err); end
        bus_read(32'h4, 2'd2, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h4, 2'd2, 1'b0)) begin bad++; $display("FAIL half_word_read: got %h exp %h", d, model_read(32'h4, 2'd2, 1'b0)); end
        bus_read(32'h6, 2'd1, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h6, 2'd1, 1'b0)) begin bad++; $display("FAIL half_read: got %h exp %h", d, model_read(32'h6, 2'd1, 1'b0)); end
        bus_read(32'h4, 2'd1, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h4, 2'd1, 1'b0)) begin bad++; $display("FAIL half_read_sext: got %h exp %h", d, model_read(32'h4, 2'd1, 1'b0)); end
    endtask

    task automatic test_errors();
        logic ack, err, ack2, early, rv;
        logic [31:0] d;
        bus_write(32'h5, 32'h0000_FFFF, 2'd1, ack, err, ack2);
        total++; if (ack !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL misaligned_write: got ack=%b err=%b exp 1/1", ack, err); end
        bus_read(32'h4, 2'd2, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h4, 2'd2, 1'b0) || err !== 1'b0) begin bad++; $display("FAIL misaligned_nowrite: got %h exp %h", d, model_read(32'h4, 2'd2, 1'b0)); end
        bus_read(32'h1000, 2'd2, 1'b0, early, rv, d, err);
        total++; if (rv !== 1'b1 || err !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL range_read: got rv=%b err=%b data=%h exp 1/1/0", rv, err, d); end
        bus_read(32'h8, 2'd3, 1'b0, early, rv, d, err);
        total++; if (rv !== 1'b1 || err !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL rsvd_read: got rv=%b err=%b data=%h exp 1/1/0", rv, err, d); end
        bus_read(32'h2, 2'd2, 1'b0, early, rv, d, err);
        total++; if (err !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL misaligned_word_read: got err=%b data=%h exp 1/0", err, d); end
        bus_write(32'h8, 32'h5555_AAAA, 2'd3, ack, err, ack2);
        total++; if (ack !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL rsvd_write: got ack=%b err=%b exp 1/1", ack, err); end
    endtask

    task automatic test_reset_mid();
        logic early, rv, err;
        logic [31:0] d;
        s_req_i = 1'b1; s_rw_i = 1'b1; s_addr_i = 32'h14; s_wdata_i = 32'hCAFE_F00D; s_byte_mask_i = 2'd2;
        @(posedge clk); #1;
        s_req_i = 1'b0; rst = 1'b1;
        model_write(32'h14, 32'hCAFE_F00D, 2'd2);
        @(posedge clk); #1;
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("FAIL rst_wack_ack: got %b exp 0", s_ack_o); end
        rst = 1'b0;
        total++; if (s_ready_o !== 1'b1) begin bad++; $display("FAIL rst_wack_ready: got %b exp 1", s_ready_o); end
        bus_read(32'h0, 2'd2, 1'b0, early, rv, d, err);
        s_req_i = 1'b1; s_rw_i = 1'b0; s_addr_i = 32'h14; s_byte_mask_i = 2'd2;
        @(posedge clk); #1;
        s_req_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        total++; if (s_rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rd_rvalid: got %b exp 0", s_rvalid_o); end
        total++; if (s_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rd_rdata: got %h exp 0", s_rdata_o); end
        rst = 1'b0;
        total++; if (s_ready_o !== 1'b1) begin bad++; $display("FAIL rst_rd_ready: got %b exp 1", s_ready_o); end
        @(posedge clk); #1;
        total++; if (s_rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rd_late_rvalid: got %b exp 0", s_rvalid_o); end
        bus_read(32'h14, 2'd2, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h14, 2'd2, 1'b0)) begin bad++; $display("FAIL rst_committed: got %h exp %h", d, model_read(32'h14, 2'd2, 1'b0)); end
    endtask

    task automatic test_back_to_back();
        logic early, rv, err;
        logic [31:0] d;
        s_req_i = 1'b1; s_rw_i = 1'b1; s_addr_i = 32'h20; s_wdata_i = 32'h1111_2222; s_byte_mask_i = 2'd2;
        @(posedge clk); #1;
        model_write(32'h20, 32'h1111_2222, 2'd2);
        s_addr_i = 32'h24; s_wdata_i = 32'h3333_4444;
        total++; if (s_ready_o !== 1'b0 || s_ack_o !== 1'b1) begin bad++; $display("FAIL b2b_wack: got ready=%b ack=%b exp 0/1", s_ready_o, s_ack_o); end
        @(posedge clk); #1;
        total++; if (s_ready_o !== 1'b1 || s_ack_o !== 1'b0) begin bad++; $display("FAIL b2b_held: got ready=%b ack=%b exp 1/0", s_ready_o, s_ack_o); end
        @(posedge clk); #1;
        s_req_i = 1'b0;
        model_write(32'h24, 32'h3333_4444, 2'd2);
        total++; if (s_ack_o !== 1'b1) begin bad++; $display("FAIL b2b_second_ack: got %b exp 1", s_ack_o); end
        @(posedge clk); #1;
        bus_read(32'h20, 2'd2, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h20, 2'd2, 1'b0)) begin bad++; $display("FAIL b2b_first_data: got %h exp %h", d, model_read(32'h20, 2'd2, 1'b0)); end
        bus_read(32'h24, 2'd2, 1'b0, early, rv, d, err);
        total++; if (d !== model_read(32'h24, 2'd2, 1'b0)) begin bad++; $display("FAIL b2b_second_data: got %h exp %h", d, model_read(32'h24, 2'd2, 1'b0)); end
    endtask

    task automatic test_random();
        logic ack, err, ack2, early, rv, un, e_err;
        logic [31:0] a, d, exp_d;
        logic [1:0] sz;
        for (int n = 0; n < 120; n++) begin
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            e_err = model_err(a, sz);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                bus_write(a, d, sz, ack, err, ack2);
                total++; if (ack !== 1'b1 || err !== e_err || ack2 !== 1'b0)
                    begin bad++; $display("FAIL rand_write a=%h sz=%0d: got ack=%b err=%b ack2=%b exp 1/%b/0", a, sz, ack, err, ack2, e_err); end
            end else begin
                exp_d = model_read(a, sz, un);
                bus_read(a, sz, un, early, rv, d, err);
                total++; if (early !== 1'b0 || rv !== 1'b1 || err !== e_err || d !== exp_d)
                    begin bad++; $display("FAIL rand_read a=%h sz=%0d un=%b: got rv=%b err=%b data=%h exp 1/%b/%h", a, sz, un, rv, err, d, e_err, exp_d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word();
        test_byte_ext();
        test_half();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
